// File: rtl/dcache_axi_line_ctl_pkg.sv
// Shared types and constants for the dcache line-transfer engine.
package axi_line_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } line_state_e;

    localparam int         LINE_BYTES     = 64;
    localparam int         LINE_BEATS     = 8;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [7:0] AXI_LEN_LINE   = 8'(LINE_BEATS - 1);

endpackage

// File: rtl/dcache_axi_line_ctl_if.sv
// AXI4 channel bundle between the line engine (master) and the memory bus (slave).
interface dcache_axi_line_ctl_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, input arready,
        input  rvalid, rdata, rresp, rlast, output rready,
        output awvalid, awaddr, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input  bvalid, bresp, output bready
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, output arready,
        output rvalid, rdata, rresp, rlast, input rready,
        input  awvalid, awaddr, awlen, awsize, awburst, output awready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bresp, input bready
    );

endinterface

// File: rtl/dcache_axi_line_ctl_line_buf.sv
// 8-entry line staging buffer: one write port, two combinational read ports.
module line_buf
    import axi_line_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_w,
    output logic [DATA_W-1:0] rdata_w,
    input  logic [2:0]        raddr_c,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem_q [LINE_BEATS];

    // Contents are deliberately not reset; every word is written before it is used.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_w = mem_q[raddr_w];
    assign rdata_c = mem_q[raddr_c];

endmodule

// File: rtl/dcache_axi_line_ctl.sv
// Line-transfer engine: stages one 64-byte line and moves it as a single
// 8-beat INCR burst (AR/R refill or AW/W/B writeback).
//
// state   | meaning
// IDLE    | waiting for req; pushes accepted
// AR      | read address presented
// R       | collecting 8 read beats into the buffer
// AW      | write address presented; pushes accepted
// W       | sending buffered words, stalling on words not yet pushed
// B       | waiting for write response
// DONE    | done high until fifo_done
module dcache_axi_line_ctl
    import axi_line_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              fifo_wen,
    input  logic [DATA_W-1:0] fifo_data_i,
    input  logic [8:0]        fifo_idx,
    input  logic              fifo_done,
    output logic              done,
    output logic [DATA_W-1:0] data_o,
    output logic              err,
    dcache_axi_line_ctl_if.master axi
);

    localparam int OFF_W = $clog2(LINE_BYTES);

    line_state_e       state_q, state_d;
    logic [2:0]        beat_q, beat_d;
    logic [3:0]        push_cnt_q, push_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic              buf_we;
    logic [2:0]        buf_waddr;
    logic [DATA_W-1:0] buf_wdata;
    logic [DATA_W-1:0] buf_rdata_w;
    logic              wvalid_int;
    logic              unused_bits;

    assign unused_bits = ^{fifo_idx[5:0], req_addr[OFF_W-1:0]};
    assign wvalid_int  = (state_q == ST_W) && ({1'b0, beat_q} < push_cnt_q);

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        push_cnt_d = push_cnt_q;
        addr_d     = addr_q;
        err_d      = err_q;
        buf_we     = 1'b0;
        buf_waddr  = push_cnt_q[2:0];
        buf_wdata  = fifo_data_i;

        // R is the only state that writes from the bus, and pushes are refused there.
        if (fifo_wen) begin
            if ((state_q inside {ST_IDLE, ST_AW, ST_W}) && (push_cnt_q < 4'(LINE_BEATS))) begin
                buf_we     = 1'b1;
                push_cnt_d = push_cnt_q + 4'd1;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    state_d = rw ? ST_AW : ST_AR;
                end
            end
            ST_AR: if (axi.arready) state_d = ST_R;
            ST_R: begin
                if (axi.rvalid) begin
                    buf_we    = 1'b1;
                    buf_waddr = beat_q;
                    buf_wdata = axi.rdata;
                    beat_d    = beat_q + 3'd1;
                    if (axi.rresp != AXI_RESP_OKAY) err_d = 1'b1;
                    if (axi.rlast) begin
                        state_d = ST_DONE;
                        if (beat_q != 3'(LINE_BEATS - 1)) err_d = 1'b1;
                    end
                end
            end
            ST_AW: if (axi.awready) state_d = ST_W;
            ST_W: begin
                if (wvalid_int && axi.wready) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'(LINE_BEATS - 1)) state_d = ST_B;
                end
            end
            ST_B: begin
                if (axi.bvalid) begin
                    state_d = ST_DONE;
                    if (axi.bresp != AXI_RESP_OKAY) err_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (fifo_done) begin
                    state_d    = ST_IDLE;
                    beat_d     = 3'd0;
                    push_cnt_d = 4'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_q     <= 3'd0;
            push_cnt_q <= 4'd0;
            addr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            push_cnt_q <= push_cnt_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
        end
    end

    line_buf #(.DATA_W(DATA_W)) u_line_buf (
        .clk     (clk),
        .we      (buf_we),
        .waddr   (buf_waddr),
        .wdata   (buf_wdata),
        .raddr_w (beat_q),
        .rdata_w (buf_rdata_w),
        .raddr_c (fifo_idx[8:6]),
        .rdata_c (data_o)
    );

    assign done        = (state_q == ST_DONE);
    assign err         = err_q;

    assign axi.arvalid = (state_q == ST_AR);
    assign axi.araddr  = addr_q;
    assign axi.arlen   = AXI_LEN_LINE;
    assign axi.arsize  = AXI_SIZE_8B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.rready  = (state_q == ST_R);

    assign axi.awvalid = (state_q == ST_AW);
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = AXI_LEN_LINE;
    assign axi.awsize  = AXI_SIZE_8B;
    assign axi.awburst = AXI_BURST_INCR;

    assign axi.wvalid  = wvalid_int;
    assign axi.wdata   = buf_rdata_w;
    assign axi.wstrb   = '1;
    assign axi.wlast   = (state_q == ST_W) && (beat_q == 3'(LINE_BEATS - 1));
    assign axi.bready  = (state_q == ST_B);

endmodule
